// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: single-entry registered bundle with a valid/ready handshake on both sides.
// Optional performance counters are enabled by defining DECODE_PERF_CNT_EN.
module riscv_decode_stage (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [3:0]  alu_op_o,
    output logic [1:0]  op_a_sel_o,
    output logic        op_b_imm_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        branch_o,
    output logic        illegal_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0] dec_cnt_o,
    output logic [31:0] illegal_cnt_o
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_XOR = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_AND = 4'b0100, ALU_SRA = 4'b0101,
                           ALU_SRL = 4'b0110, ALU_SLL = 4'b0111, ALU_LTS = 4'b1000,
                           ALU_LTU = 4'b1001, ALU_GES = 4'b1010, ALU_GEU = 4'b1011,
                           ALU_EQ  = 4'b1100, ALU_NE  = 4'b1101;

    localparam logic [1:0] OPA_RS1 = 2'b00, OPA_PC = 2'b01, OPA_ZERO = 2'b10;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  d_alu_op;
    logic [1:0]  d_op_a_sel;
    logic        d_op_b_imm;
    logic [31:0] d_imm;
    logic        d_rd_we;
    logic        d_branch;
    logic        d_illegal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_LTS;
            3'b011:  arith_op = ALU_LTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        d_alu_op   = ALU_ADD;
        d_op_a_sel = OPA_RS1;
        d_op_b_imm = 1'b1;
        d_imm      = imm_i;
        d_rd_we    = 1'b1;
        d_branch   = 1'b0;
        d_illegal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_op_b_imm = 1'b0;
                d_imm      = 32'b0;
                d_alu_op   = arith_op(funct3, funct7[5]);
                d_illegal  = !((funct7 == 7'b0) ||
                               (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                d_alu_op = arith_op(funct3, funct3 == 3'b101 && funct7[5]);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    d_imm     = {27'b0, instr_i[24:20]};
                    d_illegal = !((funct7 == 7'b0) || (funct3 == 3'b101 && funct7 == F7_ALT));
                end
            end
            OPC_BRANCH: begin
                d_op_b_imm = 1'b0;
                d_imm      = imm_b;
                d_rd_we    = 1'b0;
                d_branch   = 1'b1;
                case (funct3)
                    3'b000:  d_alu_op = ALU_EQ;
                    3'b001:  d_alu_op = ALU_NE;
                    3'b100:  d_alu_op = ALU_LTS;
                    3'b101:  d_alu_op = ALU_GES;
                    3'b110:  d_alu_op = ALU_LTU;
                    3'b111:  d_alu_op = ALU_GEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d_op_a_sel = OPA_ZERO;
                d_imm      = imm_u;
            end
            OPC_AUIPC: begin
                d_op_a_sel = OPA_PC;
                d_imm      = imm_u;
            end
            OPC_LOAD, OPC_JALR: ;
            OPC_STORE: begin
                d_imm   = imm_s;
                d_rd_we = 1'b0;
            end
            OPC_JAL: begin
                d_op_a_sel = OPA_PC;
                d_imm      = imm_j;
            end
            default: d_illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11)
            d_illegal = 1'b1;
        if (d_illegal) begin
            d_alu_op   = ALU_ADD;
            d_op_a_sel = OPA_RS1;
            d_op_b_imm = 1'b0;
            d_imm      = 32'b0;
            d_rd_we    = 1'b0;
            d_branch   = 1'b0;
        end
        if (instr_i[11:7] == 5'd0)
            d_rd_we = 1'b0;
    end

    assign instr_ready_o = !dec_valid_o || dec_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_valid_o <= 1'b0;
            alu_op_o    <= ALU_ADD;
            op_a_sel_o  <= OPA_RS1;
            op_b_imm_o  <= 1'b0;
            imm_o       <= 32'b0;
            rs1_addr_o  <= 5'd0;
            rs2_addr_o  <= 5'd0;
            rd_addr_o   <= 5'd0;
            rd_we_o     <= 1'b0;
            branch_o    <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (instr_valid_i && instr_ready_o) begin
            dec_valid_o <= 1'b1;
            alu_op_o    <= d_alu_op;
            op_a_sel_o  <= d_op_a_sel;
            op_b_imm_o  <= d_op_b_imm;
            imm_o       <= d_imm;
            rs1_addr_o  <= instr_i[19:15];
            rs2_addr_o  <= instr_i[24:20];
            rd_addr_o   <= instr_i[11:7];
            rd_we_o     <= d_rd_we;
            branch_o    <= d_branch;
            illegal_o   <= d_illegal;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // counters advance on each bundle accepted downstream and wrap naturally
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_cnt_o     <= 32'd0;
            illegal_cnt_o <= 32'd0;
        end else if (dec_valid_o && dec_ready_i) begin
            dec_cnt_o <= dec_cnt_o + 32'd1;
            if (illegal_o)
                illegal_cnt_o <= illegal_cnt_o + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: doc/riscv_decode_stage.md
RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst_n_i  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_valid_i  input  1  upstream instruction valid.
REQ-004 SHALL have port: instr_ready_o  output  1  stage can accept instruction this cycle.
REQ-005 SHALL have port: instr_i  input  32  RV32I instruction word.
REQ-006 SHALL have port: dec_valid_o  output  1  decoded bundle valid.
REQ-007 SHALL have port: dec_ready_i  input  1  downstream (ALU stage) accepts bundle.
REQ-008 SHALL have port: alu_op_o  output  4  ALU operator code; encoding ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SRA 0101, SRL 0110, SLL 0111, LTS 1000, LTU 1001, GES 1010, GEU 1011, EQ 1100, NE 1101.
REQ-009 SHALL have port: op_a_sel_o  output  2  operand A source: 00 rs1, 01 pc, 10 zero.
REQ-010 SHALL have port: op_b_imm_o  output  1  operand B: 1 imm_o, 0 rs2.
REQ-011 SHALL have port: imm_o  output  32  sign-extended immediate (I/S/B/U/J per opcode).
REQ-012 SHALL have ports: rs1_addr_o, rs2_addr_o, rd_addr_o  output  5 each  register indices from instr[19:15], [24:20], [11:7].
REQ-013 SHALL have ports: rd_we_o, branch_o, illegal_o  output  1 each  register write, conditional branch, illegal instruction.

Function
REQ-014 SHALL register all decoded outputs; latency instr handshake -> dec_valid_o = 1 cycle.
REQ-015 SHALL drive instr_ready_o = !dec_valid_o || dec_ready_i (single-entry, full throughput).
REQ-016 SHALL load a new bundle on instr_valid_i && instr_ready_o; else, if dec_ready_i, clear dec_valid_o.
REQ-017 SHALL hold all outputs stable while dec_valid_o && !dec_ready_i.
REQ-018 SHALL decode OP (0110011): funct3/funct7 -> ADD/SUB/SLL/LTS/LTU/XOR/SRL/SRA/OR/AND; funct7 only 0000000 or 0100000 (latter only for ADD->SUB, SRL->SRA).
REQ-019 SHALL decode OP-IMM (0010011) as OP with op_b_imm_o=1, no SUBI; shifts require imm[11:5]=0000000 (SRAI 0100000).
REQ-020 SHALL decode BRANCH (1100011): funct3 000 EQ, 001 NE, 100 LTS, 101 GES, 110 LTU, 111 GEU; branch_o=1, rd_we_o=0, op_b_imm_o=0.
REQ-021 SHALL decode LUI as ADD, op_a zero; AUIPC as ADD, op_a pc; LOAD/STORE/JAL/JALR as ADD with imm (STORE rd_we_o=0; JAL op_a pc).
REQ-022 SHALL flag illegal_o=1 for instr[1:0]!=11, unknown opcode, branch funct3 010/011, or bad funct7; then alu_op_o=ADD, rd_we_o=0, branch_o=0.
REQ-023 SHALL force rd_we_o=0 when rd_addr_o=0.
REQ-024 Illegal instructions SHALL still complete the valid/ready handshake.

Reset
REQ-025 On rst_n_i=0, SHALL immediately clear dec_valid_o, illegal_o, rd_we_o, branch_o; alu_op_o=0000, imm_o=0, all other outputs 0.
REQ-026 Reset mid-transfer SHALL drop the held bundle; first post-reset cycle instr_ready_o=1.

Configuration
REQ-027 Macro DECODE_PERF_CNT_EN: defined -> adds outputs dec_cnt_o[31:0], illegal_cnt_o[31:0], incremented on dec_valid_o && dec_ready_i (illegal_cnt_o only when illegal_o), wrap 0xFFFFFFFF->0, reset to 0; undefined -> ports and counters absent, other behaviour identical.

Verification
REQ-028 instr 0x002081B3 valid -> next cycle dec_valid_o=1, alu_op_o=0000, rs1=1, rs2=2, rd=3, rd_we_o=1, op_b_imm_o=0.
REQ-029 instr 0x40335293 -> alu_op_o=0101, imm_o=0x00000003, op_b_imm_o=1, rd=5, rs1=6.
REQ-030 instr 0x00208463 -> alu_op_o=1100, branch_o=1, rd_we_o=0, imm_o=0x00000008.
REQ-031 dec_ready_i=0 for 3 cycles after valid bundle -> outputs stable, instr_ready_o=0; dec_ready_i=1 -> next instr accepted same cycle, back-to-back stream at 1/cycle.
REQ-032 instr 0x00000000 -> illegal_o=1, rd_we_o=0, alu_op_o=0000; with DECODE_PERF_CNT_EN, after 4 legal + 1 illegal transfers dec_cnt_o=5, illegal_cnt_o=1.
REQ-033 rst_n_i low while dec_valid_o=1 and dec_ready_i=0 -> dec_valid_o=0 asynchronously, counters 0.
